lane_deserializer: RTL and testbench

LANE_DESERIALIZER -- requirements
Module: lane_deserializer

---
 rtl/lane_deserializer_pkg.sv | 19 +
 rtl/lane_shift_reg.sv | 27 ++
 rtl/lane_deserializer.sv | 113 +++++++++++
 tb/tb_lane_deserializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lane_deserializer_pkg.sv
// Shared constants and FSM encoding for the lane deserializer.
// Holds the default comma byte, sync run length, word width, the idle word
// and the alignment state type.
package lane_deserializer_pkg;

  localparam logic [7:0] COM_BYTE_DEF   = 8'hBC;
  localparam int         SYNC_COUNT_DEF = 4;
  localparam int         WORD_W_DEF     = 32;

  // A completed word made only of comma bytes carries no payload.
  localparam logic [WORD_W_DEF-1:0] IDLE_WORD_DEF = {(WORD_W_DEF/8){COM_BYTE_DEF}};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } lane_state_t;

endpackage

// File: rtl/lane_shift_reg.sv
// Serial-in, parallel-out shift register, new bit enters at the LSB.
// Ports: clk_32f/reset (sync, active-high), din (serial bit),
//   par_out (last WIDTH bits, including the bit currently on din).
module lane_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             din,
  output logic [WIDTH-1:0] par_out
);

  // Only WIDTH-1 history bits are stored; the newest bit comes straight
  // from din so the caller sees the window that includes the current bit.
  logic [WIDTH-2:0] hist_q;

  assign par_out = {hist_q, din};

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= par_out[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/lane_deserializer.sv
// Serial lane deserializer: comma alignment (HUNT/SYNC/ACTIVE) then word output.
// Ports: clk_32f (bit clock), reset (sync, active-high), serial_in (MSB-first),
//   data_out/valid_out (registered word + one-cycle qualifier), active (aligned).
module lane_deserializer
  import lane_deserializer_pkg::*;
#(
  parameter logic [7:0] COM_BYTE   = COM_BYTE_DEF,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEF,
  parameter int         WORD_W     = WORD_W_DEF
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              serial_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
);

  localparam int CNT_W  = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);
  localparam int WCNT_W = $clog2(WORD_W);
  localparam logic [WORD_W-1:0] IDLE_WORD = {(WORD_W/8){COM_BYTE}};
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  COM_DONE  = CNT_W'(SYNC_COUNT);

  lane_state_t        state;
  logic [2:0]         bit_cnt;
  logic [CNT_W-1:0]   com_cnt;
  logic [CNT_W-1:0]   com_inc;
  logic [WCNT_W-1:0]  wcnt;
  logic [7:0]         byte_win;
  logic [WORD_W-1:0]  word_win;

  assign com_inc = com_cnt + CNT_W'(1);

  lane_shift_reg #(.WIDTH(8)) u_byte_win (
    .clk_32f (clk_32f),
    .reset   (reset),
    .din     (serial_in),
    .par_out (byte_win)
  );

  lane_shift_reg #(.WIDTH(WORD_W)) u_word_win (
    .clk_32f (clk_32f),
    .reset   (reset),
    .din     (serial_in),
    .par_out (word_win)
  );

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= ST_HUNT;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      wcnt      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        ST_HUNT: begin
          // The bit that completes a comma becomes the byte boundary.
          if (byte_win == COM_BYTE) begin
            bit_cnt <= '0;
            wcnt    <= '0;
            com_cnt <= CNT_W'(1);
            if (SYNC_COUNT <= 1) begin
              state  <= ST_ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ST_SYNC;
            end
          end
        end

        ST_SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_win == COM_BYTE) begin
              com_cnt <= com_inc;
              if (com_inc == COM_DONE) begin
                state  <= ST_ACTIVE;
                active <= 1'b1;
                wcnt   <= '0;
              end
            end else begin
              // Broken comma run: hunt again starting with the next bit.
              state   <= ST_HUNT;
              com_cnt <= '0;
            end
          end
        end

        ST_ACTIVE: begin
          if (wcnt == WCNT_LAST) begin
            wcnt <= '0;
            if (word_win != IDLE_WORD) begin
              data_out  <= word_win;
              valid_out <= 1'b1;
            end
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end

        default: begin
          state <= ST_HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_deserializer.sv
module tb_lane_deserializer;

  localparam logic [7:0]  COM  = 8'hBC;
  localparam int          SC   = 4;
  localparam int          W    = 32;
  localparam logic [31:0] IDLE = 32'hBCBCBCBC;

  logic        clk_32f;
  logic        reset;
  logic        serial_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;

  lane_deserializer #(.COM_BYTE(COM), .SYNC_COUNT(SC), .WORD_W(W)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .serial_in (serial_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Every bit sampled since the last reset; alignment is found by searching
  // this stream for a run of SC byte-spaced commas.
  bit          hist[$];
  logic [31:0] last_data;
  logic        exp_active;
  logic        exp_valid;

  function automatic logic [7:0] win(input int p);
    logic [7:0] v = '0;
    for (int i = p - 7; i <= p; i++) v = {v[6:0], hist[i]};
    return v;
  endfunction

  function automatic logic [31:0] word_at(input int p);
    logic [31:0] v = '0;
    for (int i = p - W + 1; i <= p; i++) v = {v[30:0], hist[i]};
    return v;
  endfunction

  // Index of the bit completing the final sync comma, or -1 if not yet aligned.
  function automatic int find_active();
    int p = 7;
    while (p + 8 * (SC - 1) < hist.size()) begin
      if (win(p) == COM) begin
        int fail_k = 0;
        for (int k = 1; k < SC; k++)
          if (fail_k == 0 && win(p + 8 * k) != COM) fail_k = k;
        if (fail_k == 0) return p + 8 * (SC - 1);
        p = p + 8 * fail_k + 1;
      end else begin
        p++;
      end
    end
    return -1;
  endfunction

  // Observations used by the literal per-scenario checks.
  int          obs_active_bit;
  int          obs_pulses;
  logic [31:0] obs_pulse_data;
  int          obs_pulse_bit;

  logic cyc_rst, cyc_bit;

  always @(posedge clk_32f) begin
    int a, n;
    logic [31:0] w;
    cyc_rst = reset;
    cyc_bit = serial_in;
    #1;
    exp_valid = 1'b0;
    if (cyc_rst) begin
      hist.delete();
      last_data      = '0;
      exp_active     = 1'b0;
      obs_active_bit = -1;
      obs_pulses     = 0;
      obs_pulse_data = '0;
      obs_pulse_bit  = -1;
    end else begin
      hist.push_back(cyc_bit);
      n = hist.size() - 1;
      a = find_active();
      exp_active = (a >= 0);
      if (a >= 0 && n > a && ((n - a) % W) == 0) begin
        w = word_at(n);
        if (w != IDLE) begin
          exp_valid = 1'b1;
          last_data = w;
        end
      end
    end
    chk("active", {63'd0, active}, {63'd0, exp_active});
    chk("valid_out", {63'd0, valid_out}, {63'd0, exp_valid});
    chk("data_out", {32'd0, data_out}, {32'd0, last_data});
    if (!cyc_rst) begin
      if (active === 1'b1 && obs_active_bit < 0) obs_active_bit = hist.size();
      if (valid_out === 1'b1) begin
        obs_pulses++;
        obs_pulse_data = data_out;
        obs_pulse_bit  = hist.size();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_bit(input logic b);
    serial_in = b;
    @(negedge clk_32f);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_word(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_coms(input int cnt);
    for (int i = 0; i < cnt; i++) send_byte(COM);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    serial_in = 1'b0;
    @(negedge clk_32f);
    @(negedge clk_32f);
    chk("reset_data", {32'd0, data_out}, 64'd0);
    chk("reset_active", {63'd0, active}, 64'd0);
    reset = 1'b0;

    // Aligned commas, then one payload word.
    send_coms(4);
    send_word(32'h12345678);
    send_byte(8'h00);
    chk("t1_active_bit", 64'(obs_active_bit), 64'd32);
    chk("t1_pulses", 64'(obs_pulses), 64'd1);
    chk("t1_data", {32'd0, obs_pulse_data}, 64'h12345678);
    chk("t1_pulse_bit", 64'(obs_pulse_bit), 64'd64);

    // Three junk bits shift the byte boundary.
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_coms(4);
    send_word(32'hCAFEF00D);
    send_byte(8'h00);
    chk("t2_active_bit", 64'(obs_active_bit), 64'd35);
    chk("t2_pulses", 64'(obs_pulses), 64'd1);
    chk("t2_data", {32'd0, obs_pulse_data}, 64'hCAFEF00D);

    // Broken comma run must restart the hunt.
    do_reset();
    send_coms(3);
    send_byte(8'h00);
    send_coms(4);
    send_word(32'hA5A5A5A5);
    send_byte(8'h00);
    chk("t3_active_bit", 64'(obs_active_bit), 64'd64);
    chk("t3_pulses", 64'(obs_pulses), 64'd1);
    chk("t3_data", {32'd0, obs_pulse_data}, 64'hA5A5A5A5);

    // Idle word is suppressed; following word is delivered and held.
    do_reset();
    send_coms(4);
    send_word(32'hBCBCBCBC);
    send_word(32'h00000001);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("t4_pulses", 64'(obs_pulses), 64'd1);
    chk("t4_pulse_bit", 64'(obs_pulse_bit), 64'd96);
    chk("t4_data_hold", {32'd0, data_out}, 64'd1);

    // Reset halfway through an active word.
    do_reset();
    send_coms(4);
    send_byte(8'hFF);
    send_byte(8'hFF);
    chk("t5_pre_active", {63'd0, active}, 64'd1);
    chk("t5_pre_pulses", 64'(obs_pulses), 64'd0);
    do_reset();
    chk("t5_rst_active", {63'd0, active}, 64'd0);
    chk("t5_rst_valid", {63'd0, valid_out}, 64'd0);
    chk("t5_rst_data", {32'd0, data_out}, 64'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_coms(4);
    send_word(32'h0BADF00D);
    send_byte(8'h00);
    chk("t5_active_bit", 64'(obs_active_bit), 64'd48);
    chk("t5_pulses", 64'(obs_pulses), 64'd1);
    chk("t5_data", {32'd0, obs_pulse_data}, 64'h0BADF00D);

    // Random traffic around a comma run, checked by the model alone.
    do_reset();
    for (int i = 0; i < 13; i++) send_bit(1'($urandom_range(0, 1)));
    send_coms(4);
    for (int i = 0; i < 160; i++) send_bit(1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
